inv_sub_bytes_seq: RTL and testbench

//  Iterative AES InvSubBytes engine for the decryption datapath: the inverse of the forward SubBytes stage.

---
 rtl/inv_sub_bytes_seq_pkg.sv | 22 ++
 rtl/inv_sub_bytes_seq_if.sv | 25 ++
 rtl/inv_sub_bytes_seq_sbox.sv | 80 ++++++++
 rtl/inv_sub_bytes_seq.sv | 115 +++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared AES definitions: block geometry, engine FSM encoding and byte-slice helper.
package aes_defs;

    localparam int AES_BLOCK_BITS = 128;
    localparam int AES_NUM_BYTES  = 16;

    // Engine FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // The state is numbered big-endian: byte 0 occupies bits [0:7].
    typedef logic [0:AES_BLOCK_BITS-1] aes_block_t;

    // Byte k of a state, i.e. bits [8k:8k+7].
    function automatic logic [7:0] get_byte(input aes_block_t blk, input int k);
        return blk[8*k +: 8];
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready input and output channels of the InvSubBytes engine.
interface inv_sub_bytes_seq_if;
    import aes_defs::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t in_state;
    logic       out_valid;
    logic       out_ready;
    aes_block_t out_state;
    logic       busy;

    // Producer/consumer side of the engine.
    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    // The engine itself.
    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/inv_sub_bytes_seq_sbox.sv
// One lane of the FIPS-197 inverse S-box, purely combinational and total over 0..255.
module inv_sbox_byte (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Table lookup of the inverse S-box.
    always_comb begin
        // NOTE: the default assignment ahead of the case keeps every path driven, so no latch is inferred.
        byte_o = 8'h00;
        case (byte_i)
            8'h00: byte_o = 8'h52; 8'h01: byte_o = 8'h09; 8'h02: byte_o = 8'h6a; 8'h03: byte_o = 8'hd5;
            8'h04: byte_o = 8'h30; 8'h05: byte_o = 8'h36; 8'h06: byte_o = 8'ha5; 8'h07: byte_o = 8'h38;
            8'h08: byte_o = 8'hbf; 8'h09: byte_o = 8'h40; 8'h0a: byte_o = 8'ha3; 8'h0b: byte_o = 8'h9e;
            8'h0c: byte_o = 8'h81; 8'h0d: byte_o = 8'hf3; 8'h0e: byte_o = 8'hd7; 8'h0f: byte_o = 8'hfb;
            8'h10: byte_o = 8'h7c; 8'h11: byte_o = 8'he3; 8'h12: byte_o = 8'h39; 8'h13: byte_o = 8'h82;
            8'h14: byte_o = 8'h9b; 8'h15: byte_o = 8'h2f; 8'h16: byte_o = 8'hff; 8'h17: byte_o = 8'h87;
            8'h18: byte_o = 8'h34; 8'h19: byte_o = 8'h8e; 8'h1a: byte_o = 8'h43; 8'h1b: byte_o = 8'h44;
            8'h1c: byte_o = 8'hc4; 8'h1d: byte_o = 8'hde; 8'h1e: byte_o = 8'he9; 8'h1f: byte_o = 8'hcb;
            8'h20: byte_o = 8'h54; 8'h21: byte_o = 8'h7b; 8'h22: byte_o = 8'h94; 8'h23: byte_o = 8'h32;
            8'h24: byte_o = 8'ha6; 8'h25: byte_o = 8'hc2; 8'h26: byte_o = 8'h23; 8'h27: byte_o = 8'h3d;
            8'h28: byte_o = 8'hee; 8'h29: byte_o = 8'h4c; 8'h2a: byte_o = 8'h95; 8'h2b: byte_o = 8'h0b;
            8'h2c: byte_o = 8'h42; 8'h2d: byte_o = 8'hfa; 8'h2e: byte_o = 8'hc3; 8'h2f: byte_o = 8'h4e;
            8'h30: byte_o = 8'h08; 8'h31: byte_o = 8'h2e; 8'h32: byte_o = 8'ha1; 8'h33: byte_o = 8'h66;
            8'h34: byte_o = 8'h28; 8'h35: byte_o = 8'hd9; 8'h36: byte_o = 8'h24; 8'h37: byte_o = 8'hb2;
            8'h38: byte_o = 8'h76; 8'h39: byte_o = 8'h5b; 8'h3a: byte_o = 8'ha2; 8'h3b: byte_o = 8'h49;
            8'h3c: byte_o = 8'h6d; 8'h3d: byte_o = 8'h8b; 8'h3e: byte_o = 8'hd1; 8'h3f: byte_o = 8'h25;
            8'h40: byte_o = 8'h72; 8'h41: byte_o = 8'hf8; 8'h42: byte_o = 8'hf6; 8'h43: byte_o = 8'h64;
            8'h44: byte_o = 8'h86; 8'h45: byte_o = 8'h68; 8'h46: byte_o = 8'h98; 8'h47: byte_o = 8'h16;
            8'h48: byte_o = 8'hd4; 8'h49: byte_o = 8'ha4; 8'h4a: byte_o = 8'h5c; 8'h4b: byte_o = 8'hcc;
            8'h4c: byte_o = 8'h5d; 8'h4d: byte_o = 8'h65; 8'h4e: byte_o = 8'hb6; 8'h4f: byte_o = 8'h92;
            8'h50: byte_o = 8'h6c; 8'h51: byte_o = 8'h70; 8'h52: byte_o = 8'h48; 8'h53: byte_o = 8'h50;
            8'h54: byte_o = 8'hfd; 8'h55: byte_o = 8'hed; 8'h56: byte_o = 8'hb9; 8'h57: byte_o = 8'hda;
            8'h58: byte_o = 8'h5e; 8'h59: byte_o = 8'h15; 8'h5a: byte_o = 8'h46; 8'h5b: byte_o = 8'h57;
            8'h5c: byte_o = 8'ha7; 8'h5d: byte_o = 8'h8d; 8'h5e: byte_o = 8'h9d; 8'h5f: byte_o = 8'h84;
            8'h60: byte_o = 8'h90; 8'h61: byte_o = 8'hd8; 8'h62: byte_o = 8'hab; 8'h63: byte_o = 8'h00;
            8'h64: byte_o = 8'h8c; 8'h65: byte_o = 8'hbc; 8'h66: byte_o = 8'hd3; 8'h67: byte_o = 8'h0a;
            8'h68: byte_o = 8'hf7; 8'h69: byte_o = 8'he4; 8'h6a: byte_o = 8'h58; 8'h6b: byte_o = 8'h05;
            8'h6c: byte_o = 8'hb8; 8'h6d: byte_o = 8'hb3; 8'h6e: byte_o = 8'h45; 8'h6f: byte_o = 8'h06;
            8'h70: byte_o = 8'hd0; 8'h71: byte_o = 8'h2c; 8'h72: byte_o = 8'h1e; 8'h73: byte_o = 8'h8f;
            8'h74: byte_o = 8'hca; 8'h75: byte_o = 8'h3f; 8'h76: byte_o = 8'h0f; 8'h77: byte_o = 8'h02;
            8'h78: byte_o = 8'hc1; 8'h79: byte_o = 8'haf; 8'h7a: byte_o = 8'hbd; 8'h7b: byte_o = 8'h03;
            8'h7c: byte_o = 8'h01; 8'h7d: byte_o = 8'h13; 8'h7e: byte_o = 8'h8a; 8'h7f: byte_o = 8'h6b;
            8'h80: byte_o = 8'h3a; 8'h81: byte_o = 8'h91; 8'h82: byte_o = 8'h11; 8'h83: byte_o = 8'h41;
            8'h84: byte_o = 8'h4f; 8'h85: byte_o = 8'h67; 8'h86: byte_o = 8'hdc; 8'h87: byte_o = 8'hea;
            8'h88: byte_o = 8'h97; 8'h89: byte_o = 8'hf2; 8'h8a: byte_o = 8'hcf; 8'h8b: byte_o = 8'hce;
            8'h8c: byte_o = 8'hf0; 8'h8d: byte_o = 8'hb4; 8'h8e: byte_o = 8'he6; 8'h8f: byte_o = 8'h73;
            8'h90: byte_o = 8'h96; 8'h91: byte_o = 8'hac; 8'h92: byte_o = 8'h74; 8'h93: byte_o = 8'h22;
            8'h94: byte_o = 8'he7; 8'h95: byte_o = 8'had; 8'h96: byte_o = 8'h35; 8'h97: byte_o = 8'h85;
            8'h98: byte_o = 8'he2; 8'h99: byte_o = 8'hf9; 8'h9a: byte_o = 8'h37; 8'h9b: byte_o = 8'he8;
            8'h9c: byte_o = 8'h1c; 8'h9d: byte_o = 8'h75; 8'h9e: byte_o = 8'hdf; 8'h9f: byte_o = 8'h6e;
            8'ha0: byte_o = 8'h47; 8'ha1: byte_o = 8'hf1; 8'ha2: byte_o = 8'h1a; 8'ha3: byte_o = 8'h71;
            8'ha4: byte_o = 8'h1d; 8'ha5: byte_o = 8'h29; 8'ha6: byte_o = 8'hc5; 8'ha7: byte_o = 8'h89;
            8'ha8: byte_o = 8'h6f; 8'ha9: byte_o = 8'hb7; 8'haa: byte_o = 8'h62; 8'hab: byte_o = 8'h0e;
            8'hac: byte_o = 8'haa; 8'had: byte_o = 8'h18; 8'hae: byte_o = 8'hbe; 8'haf: byte_o = 8'h1b;
            8'hb0: byte_o = 8'hfc; 8'hb1: byte_o = 8'h56; 8'hb2: byte_o = 8'h3e; 8'hb3: byte_o = 8'h4b;
            8'hb4: byte_o = 8'hc6; 8'hb5: byte_o = 8'hd2; 8'hb6: byte_o = 8'h79; 8'hb7: byte_o = 8'h20;
            8'hb8: byte_o = 8'h9a; 8'hb9: byte_o = 8'hdb; 8'hba: byte_o = 8'hc0; 8'hbb: byte_o = 8'hfe;
            8'hbc: byte_o = 8'h78; 8'hbd: byte_o = 8'hcd; 8'hbe: byte_o = 8'h5a; 8'hbf: byte_o = 8'hf4;
            8'hc0: byte_o = 8'h1f; 8'hc1: byte_o = 8'hdd; 8'hc2: byte_o = 8'ha8; 8'hc3: byte_o = 8'h33;
            8'hc4: byte_o = 8'h88; 8'hc5: byte_o = 8'h07; 8'hc6: byte_o = 8'hc7; 8'hc7: byte_o = 8'h31;
            8'hc8: byte_o = 8'hb1; 8'hc9: byte_o = 8'h12; 8'hca: byte_o = 8'h10; 8'hcb: byte_o = 8'h59;
            8'hcc: byte_o = 8'h27; 8'hcd: byte_o = 8'h80; 8'hce: byte_o = 8'hec; 8'hcf: byte_o = 8'h5f;
            8'hd0: byte_o = 8'h60; 8'hd1: byte_o = 8'h51; 8'hd2: byte_o = 8'h7f; 8'hd3: byte_o = 8'ha9;
            8'hd4: byte_o = 8'h19; 8'hd5: byte_o = 8'hb5; 8'hd6: byte_o = 8'h4a; 8'hd7: byte_o = 8'h0d;
            8'hd8: byte_o = 8'h2d; 8'hd9: byte_o = 8'he5; 8'hda: byte_o = 8'h7a; 8'hdb: byte_o = 8'h9f;
            8'hdc: byte_o = 8'h93; 8'hdd: byte_o = 8'hc9; 8'hde: byte_o = 8'h9c; 8'hdf: byte_o = 8'hef;
            8'he0: byte_o = 8'ha0; 8'he1: byte_o = 8'he0; 8'he2: byte_o = 8'h3b; 8'he3: byte_o = 8'h4d;
            8'he4: byte_o = 8'hae; 8'he5: byte_o = 8'h2a; 8'he6: byte_o = 8'hf5; 8'he7: byte_o = 8'hb0;
            8'he8: byte_o = 8'hc8; 8'he9: byte_o = 8'heb; 8'hea: byte_o = 8'hbb; 8'heb: byte_o = 8'h3c;
            8'hec: byte_o = 8'h83; 8'hed: byte_o = 8'h53; 8'hee: byte_o = 8'h99; 8'hef: byte_o = 8'h61;
            8'hf0: byte_o = 8'h17; 8'hf1: byte_o = 8'h2b; 8'hf2: byte_o = 8'h04; 8'hf3: byte_o = 8'h7e;
            8'hf4: byte_o = 8'hba; 8'hf5: byte_o = 8'h77; 8'hf6: byte_o = 8'hd6; 8'hf7: byte_o = 8'h26;
            8'hf8: byte_o = 8'he1; 8'hf9: byte_o = 8'h69; 8'hfa: byte_o = 8'h14; 8'hfb: byte_o = 8'h63;
            8'hfc: byte_o = 8'h55; 8'hfd: byte_o = 8'h21; 8'hfe: byte_o = 8'h0c; 8'hff: byte_o = 8'h7d;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: BYTES_PER_CYCLE inverse S-box lanes walk the
// 16-byte state, one group of lanes per clock, behind valid/ready handshakes.
module inv_sub_bytes_seq
    import aes_defs::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    inv_sub_bytes_seq_if.slave sb
);

    localparam int BPC       = BYTES_PER_CYCLE;
    localparam int BPC_SAFE  = (BPC < 1) ? 1 : BPC;
    localparam int NUM_STEPS = AES_NUM_BYTES / BPC_SAFE;
    localparam logic [3:0] LAST_CNT = 4'(NUM_STEPS - 1);

    // Lane counts that do not tile the 16-byte state are rejected at elaboration.
    if (BPC < 1 || BPC > AES_NUM_BYTES || (AES_NUM_BYTES % BPC_SAFE) != 0) begin : g_bad_bpc
        $fatal(1, "inv_sub_bytes_seq: BYTES_PER_CYCLE=%0d must be one of 1,2,4,8,16", BPC);
    end

    fsm_e       state_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       last_step;
    aes_block_t src_q;
    aes_block_t res_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;

    logic [7:0] lane_in  [BPC_SAFE];
    logic [7:0] lane_out [BPC_SAFE];

    // State byte handled by a given lane during a given step.
    function automatic int lane_pos(input logic [3:0] step, input int lane);
        return (int'(step) * BPC_SAFE + lane) % AES_NUM_BYTES;
    endfunction

    // Select this step's source bytes and compute the following step count.
    always_comb begin
        last_step = (cnt_q == LAST_CNT);
        cnt_d     = last_step ? 4'd0 : cnt_q + 4'd1;
        for (int l = 0; l < BPC_SAFE; l++) begin
            lane_in[l] = get_byte(src_q, lane_pos(cnt_q, l));
        end
    end

    for (genvar g = 0; g < BPC_SAFE; g++) begin : g_lane
        inv_sbox_byte u_sbox (
            .byte_i (lane_in[g]),
            .byte_o (lane_out[g])
        );
    end

    // Control FSM with registered handshake outputs and the working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the 128-bit working registers are cleared on reset because out_state is visible
            // between blocks and must read zero after reset, not left uninitialised like plain storage.
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            src_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
            case (state_q)
                IDLE: begin
                    if (sb.in_valid && in_ready_q) begin
                        src_q      <= sb.in_state;
                        cnt_q      <= 4'd0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int l = 0; l < BPC_SAFE; l++) begin
                        res_q[8*lane_pos(cnt_q, l) +: 8] <= lane_out[l];
                    end
                    cnt_q <= cnt_d;
                    if (last_step) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (sb.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sb.in_ready  = in_ready_q;
    assign sb.out_valid = out_valid_q;
    assign sb.out_state = res_q;
    assign sb.busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: directed scenarios on a BPC=4 instance plus a
// randomized sweep over every legal lane count, checked by a queue scoreboard
// against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;
    import aes_defs::*;

    typedef logic [0:127] blk_t;

    localparam int SW_N = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sweep_rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    logic [7:0] c_in  [4] = '{8'h63, 8'h16, 8'h00, 8'hed};
    logic [7:0] c_out [4] = '{8'h00, 8'hff, 8'h52, 8'h53};

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        for (int y = 1; y < 256; y++) begin
            if (gf_mul(x, 8'(y)) == 8'h01) return 8'(y);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] r, t;
        r = b;
        for (int n = 1; n <= 4; n++) begin
            t = (b << n) | (b >> (8 - n));
            r = r ^ t;
        end
        return r ^ 8'h63;
    endfunction

    function automatic blk_t ref_inv(input blk_t b);
        blk_t r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[b[8*k +: 8]];
        return r;
    endfunction

    function automatic blk_t ref_fwd(input blk_t b);
        blk_t r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = fwd_tab[b[8*k +: 8]];
        return r;
    endfunction

    function automatic blk_t rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- directed instance (BPC=4) ----------------
    inv_sub_bytes_seq_if d_if ();

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (d_if.slave)
    );

    blk_t d_exp_q[$];
    int   d_pops = 0;

    // Scoreboard monitor: compare every output handshake against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && d_if.out_valid === 1'b1 && d_if.out_ready === 1'b1) begin
                if (d_exp_q.size() == 0) fail("d_unexpected_output");
                else check("d_result", d_if.out_state, d_exp_q.pop_front());
                d_pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, queue its expectation on acceptance, return cycles until out_valid.
    task automatic run_block(input blk_t d, input blk_t exp, output int lat);
        int w;
        w   = 0;
        lat = -1;
        d_if.in_valid = 1'b1;
        d_if.in_state = d;
        while (d_if.in_ready !== 1'b1 && w < 100) begin tick(); w++; end
        if (d_if.in_ready !== 1'b1) begin
            fail("d_accept_timeout");
            d_if.in_valid = 1'b0;
            return;
        end
        d_exp_q.push_back(exp);
        tick();
        d_if.in_valid = 1'b0;
        d_if.in_state = ~d;
        lat = 0;
        while (d_if.out_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
    endtask

    // ---------------- parameter sweep ----------------
    for (genvar gi = 0; gi < 5; gi++) begin : g_sw
        localparam int BPC = 1 << gi;

        inv_sub_bytes_seq_if s_if ();

        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
            .clk   (clk),
            .rst_n (sweep_rst_n),
            .sb    (s_if.slave)
        );

        blk_t exp_q[$];
        blk_t src_q[$];
        int   acc_q[$];
        logic done_f = 1'b0;

        // Random downstream backpressure.
        initial begin
            s_if.out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                s_if.out_ready = ($urandom_range(0, 3) != 0);
            end
        end

        // Stimulus: random blocks, expectation pushed at the accepting edge.
        initial begin
            blk_t d;
            int   w;
            s_if.in_valid = 1'b0;
            s_if.in_state = '0;
            wait (sweep_rst_n === 1'b1);
            for (int n = 0; n < SW_N; n++) begin
                @(posedge clk);
                #1;
                d = rand_blk();
                s_if.in_valid = 1'b1;
                s_if.in_state = d;
                w = 0;
                while (s_if.in_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
                if (s_if.in_ready !== 1'b1) begin
                    fail($sformatf("sw%0d_accept_timeout", BPC));
                    break;
                end
                exp_q.push_back(ref_inv(d));
                src_q.push_back(d);
                @(posedge clk);
                #1;
                acc_q.push_back(cyc);
                s_if.in_valid = 1'b0;
                s_if.in_state = ~d;
            end
            w = 0;
            while (exp_q.size() != 0 && w < 500) begin @(posedge clk); w++; end
            check_int($sformatf("sw%0d_drained", BPC), exp_q.size(), 0);
            done_f = 1'b1;
        end

        // Monitor: latency on out_valid rise, data and round-trip on each handshake.
        initial begin
            logic prev_v;
            blk_t r;
            prev_v = 1'b0;
            forever begin
                @(negedge clk);
                if (sweep_rst_n === 1'b1) begin
                    if (s_if.out_valid === 1'b1 && prev_v !== 1'b1) begin
                        if (acc_q.size() == 0) fail($sformatf("sw%0d_valid_without_accept", BPC));
                        else check_int($sformatf("sw%0d_latency", BPC), cyc - acc_q.pop_front(), 16 / BPC);
                    end
                    if (s_if.out_valid === 1'b1 && s_if.out_ready === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            fail($sformatf("sw%0d_unexpected_output", BPC));
                        end else begin
                            r = s_if.out_state;
                            check($sformatf("sw%0d_result", BPC), r, exp_q.pop_front());
                            check($sformatf("sw%0d_fwd_roundtrip", BPC), ref_fwd(r), src_q.pop_front());
                        end
                    end
                    prev_v = s_if.out_valid;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        blk_t d, d2, snap;
        int   lat, w, pops0;

        for (int x = 0; x < 256; x++) begin
            fwd_tab[x] = affine(gf_inv(8'(x)));
            inv_tab[fwd_tab[x]] = 8'(x);
        end

        rst_n       = 1'b0;
        sweep_rst_n = 1'b0;
        d_if.in_valid  = 1'b0;
        d_if.in_state  = '0;
        d_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_in_ready", d_if.in_ready, 1'b1);
        check_bit("rst_out_valid", d_if.out_valid, 1'b0);
        check("rst_out_state", d_if.out_state, '0);
        check_bit("rst_busy", d_if.busy, 1'b0);
        @(negedge clk);
        rst_n       = 1'b1;
        sweep_rst_n = 1'b1;
        tick();

        // Known vector: forward S-box of 00..0f inverts to the identity sequence.
        d_if.out_ready = 1'b1;
        run_block(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, lat);
        check_int("known_latency", lat, 4);
        check_bit("known_busy_in_done", d_if.busy, 1'b1);
        tick();

        // Corner bytes replicated across the whole state.
        for (int i = 0; i < 4; i++) begin
            run_block({16{c_in[i]}}, {16{c_out[i]}}, lat);
            check_int($sformatf("corner_%0d_latency", i), lat, 4);
            tick();
        end

        // Backpressure: result held, nothing captured, in_ready returns after release.
        d_if.out_ready = 1'b0;
        d = rand_blk();
        run_block(d, ref_inv(d), lat);
        check_int("bp_latency", lat, 4);
        snap = d_if.out_state;
        check("bp_result", snap, ref_inv(d));
        d_if.in_valid = 1'b1;
        d_if.in_state = ~d;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_bit("bp_out_valid_held", d_if.out_valid, 1'b1);
            check("bp_out_state_held", d_if.out_state, snap);
            check_bit("bp_in_ready_low", d_if.in_ready, 1'b0);
            check_bit("bp_busy", d_if.busy, 1'b1);
        end
        d_if.in_valid = 1'b0;
        d_if.out_ready = 1'b1;
        tick();
        check_bit("bp_release_in_ready", d_if.in_ready, 1'b1);
        check_bit("bp_release_out_valid", d_if.out_valid, 1'b0);
        check_bit("bp_release_busy", d_if.busy, 1'b0);
        check("bp_release_state_kept", d_if.out_state, snap);

        // Back-to-back: in_valid held across two blocks, results must come out in order.
        pops0 = d_pops;
        d  = rand_blk();
        d2 = rand_blk();
        d_if.in_valid = 1'b1;
        d_if.in_state = d;
        w = 0;
        while (d_if.in_ready !== 1'b1 && w < 100) begin tick(); w++; end
        d_exp_q.push_back(ref_inv(d));
        tick();
        d_if.in_state = d2;
        d_exp_q.push_back(ref_inv(d2));
        w = 0;
        while (d_if.in_ready !== 1'b1 && w < 100) begin tick(); w++; end
        tick();
        d_if.in_valid = 1'b0;
        w = 0;
        while (d_pops < pops0 + 2 && w < 100) begin tick(); w++; end
        check_int("b2b_result_count", d_pops - pops0, 2);

        // Reset two cycles into RUN aborts the block immediately.
        d = rand_blk();
        d_if.in_valid = 1'b1;
        d_if.in_state = d;
        w = 0;
        while (d_if.in_ready !== 1'b1 && w < 100) begin tick(); w++; end
        tick();
        d_if.in_valid = 1'b0;
        tick();
        tick();
        check_bit("abort_busy_before", d_if.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("abort_out_valid", d_if.out_valid, 1'b0);
        check("abort_out_state", d_if.out_state, '0);
        check_bit("abort_in_ready", d_if.in_ready, 1'b1);
        check_bit("abort_busy", d_if.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        d2 = rand_blk();
        run_block(d2, ref_inv(d2), lat);
        check_int("post_abort_latency", lat, 4);
        tick();

        // A few random blocks on the directed instance.
        for (int i = 0; i < 8; i++) begin
            d = rand_blk();
            run_block(d, ref_inv(d), lat);
            check_int("rand_latency", lat, 4);
            tick();
        end

        w = 0;
        while (!(g_sw[0].done_f && g_sw[1].done_f && g_sw[2].done_f &&
                 g_sw[3].done_f && g_sw[4].done_f) && w < 80000) begin
            @(posedge clk);
            w++;
        end
        if (w >= 80000) fail("sweep_timeout");
        check_int("d_queue_drained", d_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
